// File: rtl/delay_meas_pkg.sv
// Shared types and constants for the measure-delay sequencing controller.
package delay_meas_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meas_state_t;

endpackage

// File: rtl/delay_meas_ctrl_if.sv
// Host handshake plus external counter hookup for delay_meas_ctrl.
interface delay_meas_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             arm;
  logic             result_ack;
  logic [WIDTH-1:0] ctr_q;
  logic             ctr_load;
  logic             ctr_en;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic             busy;

  // Controller side
  modport master (
    input  arm, result_ack, ctr_q,
    output ctr_load, ctr_en, result, result_valid, overflow, busy
  );

  // Host / counter side
  modport slave (
    output arm, result_ack, ctr_q,
    input  ctr_load, ctr_en, result, result_valid, overflow, busy
  );

endinterface

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin followed by a registered
// rising-edge detector producing a single-cycle pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  // Synchroniser chain, previous-level flop and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      rise    <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
    end
  end

endmodule

// File: rtl/delay_meas_ctrl.sv
// Sequencing controller for the measure-delay counter: synchronises START/STOP,
// drives the external counter's load/enable, captures and holds the result.
module delay_meas_ctrl
  import delay_meas_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start_in,
  input  logic                stop_in,
  delay_meas_ctrl_if.master   bus
);

  meas_state_t      state;
  logic             start_edge;
  logic             stop_edge;
  logic             load_c;
  logic             en_c;
  logic [WIDTH-1:0] result_r;
  logic             valid_r;
  logic             ovf_r;
  logic             busy_r;

  // Counter is about to saturate; it must never be allowed to wrap.
  function automatic logic at_limit(input logic [WIDTH-1:0] q);
    return &q;
  endfunction

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (start_in),
    .rise (start_edge)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (stop_in),
    .rise (stop_edge)
  );

  // Counter load/enable decoded from state and the registered edge pulses
  always_comb begin
    load_c = 1'b0;
    en_c   = 1'b0;
    if (ena) begin
      case (state)
        IDLE:    load_c = bus.arm;
        ARMED:   en_c   = start_edge & ~stop_edge;
        COUNT:   en_c   = ~at_limit(bus.ctr_q);
        default: ;
      endcase
    end
  end

  // Measurement FSM with registered result, status and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_r <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else if (!ena) begin
      state   <= IDLE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state   <= ARMED;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ARMED: begin
          if (start_edge && stop_edge) begin
            state    <= DONE;
            result_r <= '0;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
          end else if (start_edge) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (stop_edge) begin
            state    <= DONE;
            result_r <= bus.ctr_q;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
          end else if (at_limit(bus.ctr_q)) begin
            state    <= DONE;
            result_r <= '1;
            ovf_r    <= 1'b1;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.result_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctr_load     = load_c;
  assign bus.ctr_en       = en_c;
  assign bus.result       = result_r;
  assign bus.result_valid = valid_r;
  assign bus.overflow     = ovf_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Bench for delay_meas_ctrl: table of delay vectors, randomized delays against
// a pin-timing reference model, and hand sequences for handshake and aborts.
module tb_delay_meas_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start_in = 1'b0;
  logic       stop_in = 1'b0;
  logic [7:0] cnt = 8'd0;

  int total = 0;
  int bad = 0;
  int both_hi = 0;

  delay_meas_ctrl_if #(.WIDTH(8)) bus ();

  delay_meas_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start_in(start_in),
    .stop_in (stop_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // External counter: load to 0, else increment when enabled
  always @(posedge clk) begin
    if (bus.ctr_load) cnt <= 8'd0;
    else if (bus.ctr_en) cnt <= cnt + 8'd1;
  end
  assign bus.ctr_q = cnt;

  // load and enable must be mutually exclusive in every cycle
  always @(negedge clk) begin
    if (bus.ctr_load && bus.ctr_en) both_hi++;
  end

  typedef struct {
    int         n;
    bit         do_stop;
    logic [7:0] exp_res;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a stop N cycles after start reads N, unless the counter would
  // pass 2^8-1 first, in which case the result saturates with overflow.
  function automatic logic [8:0] ref_meas(input int n, input bit do_stop);
    if (do_stop && n <= 255) return {1'b0, 8'(n)};
    return {1'b1, 8'd255};
  endfunction

  task automatic wait_valid(output int lat, output bit tmo);
    tmo = 1'b1;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) begin
        lat = i;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic arm_pulse();
    @(negedge clk);
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic ack_result();
    @(negedge clk);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
  endtask

  task automatic pins_low();
    start_in = 1'b0;
    stop_in  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Start pin rises, stop pin rises n cycles later (or never); result left unacked
  task automatic measure(input string tag, input int n, input bit do_stop,
                         input logic [7:0] exp_res, input logic exp_ovf);
    int lat;
    bit tmo;
    pins_low();
    arm_pulse();
    start_in = 1'b1;
    repeat (n) @(negedge clk);
    if (do_stop) stop_in = 1'b1;
    wait_valid(lat, tmo);
    chk({tag, "_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    if (do_stop && n <= 255) chk({tag, "_lat"}, 32'(lat), 32'd4);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    bit tmo;
    logic [8:0] r;
    int n;
    bit ds;

    vecs[0] = '{37,  1'b1, 8'd37,  1'b0};
    vecs[1] = '{1,   1'b1, 8'd1,   1'b0};
    vecs[2] = '{0,   1'b1, 8'd0,   1'b0};
    vecs[3] = '{254, 1'b1, 8'd254, 1'b0};
    vecs[4] = '{255, 1'b1, 8'd255, 1'b0};
    vecs[5] = '{256, 1'b1, 8'd255, 1'b1};
    vecs[6] = '{120, 1'b1, 8'd120, 1'b0};

    bus.arm = 1'b0;
    bus.result_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_load", 32'(bus.ctr_load), 32'd0);
    chk("rst_en", 32'(bus.ctr_en), 32'd0);
    rst_n = 1'b1;

    // Table-driven delays
    for (int i = 0; i < 7; i++) begin
      measure($sformatf("vec%0d", i), vecs[i].n, vecs[i].do_stop, vecs[i].exp_res, vecs[i].exp_ovf);
      ack_result();
    end

    // Saturation without stop: counter parks at 255 and enable stays low
    measure("sat", 300, 1'b0, 8'd255, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("sat_cnt", 32'(cnt), 32'd255);
      chk("sat_en", 32'(bus.ctr_en), 32'd0);
      @(negedge clk);
    end
    ack_result();

    // Randomized delays against the reference model
    for (int i = 0; i < 8; i++) begin
      n  = int'($urandom_range(0, 300));
      ds = (n < 300) ? ($urandom_range(0, 9) != 0) : 1'b0;
      r  = ref_meas(n, ds);
      measure($sformatf("rnd%0d_n%0d", i, n), n, ds, r[7:0], r[8]);
      ack_result();
    end

    // Stop before start is ignored while armed
    pins_low();
    arm_pulse();
    stop_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("early_stop_busy", 32'(bus.busy), 32'd1);
    chk("early_stop_valid", 32'(bus.result_valid), 32'd0);
    stop_in = 1'b0;
    repeat (4) @(negedge clk);
    start_in = 1'b1;
    repeat (10) @(negedge clk);
    stop_in = 1'b1;
    wait_valid(lat, tmo);
    chk("early_stop_timeout", 32'(tmo), 32'd0);
    chk("early_stop_result", 32'(bus.result), 32'd10);

    // Arm in DONE without ack is ignored
    @(negedge clk);
    bus.arm = 1'b1;
    #1;
    chk("done_arm_load", 32'(bus.ctr_load), 32'd0);
    @(negedge clk);
    bus.arm = 1'b0;
    chk("done_arm_valid", 32'(bus.result_valid), 32'd1);
    chk("done_arm_busy", 32'(bus.busy), 32'd0);

    // Arm with ack: back to IDLE only, result retained
    @(negedge clk);
    bus.arm = 1'b1;
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    bus.result_ack = 1'b0;
    @(negedge clk);
    chk("ack_busy", 32'(bus.busy), 32'd0);
    chk("ack_result", 32'(bus.result), 32'd10);

    // Fresh arm: one-cycle load, valid cleared
    bus.arm = 1'b1;
    #1;
    chk("rearm_load", 32'(bus.ctr_load), 32'd1);
    @(negedge clk);
    bus.arm = 1'b0;
    #1;
    chk("rearm_load_drop", 32'(bus.ctr_load), 32'd0);
    chk("rearm_valid", 32'(bus.result_valid), 32'd0);
    chk("rearm_busy", 32'(bus.busy), 32'd1);

    // ena low during COUNT
    pins_low();
    start_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("ena_pre_en", 32'(bus.ctr_en), 32'd1);
    ena = 1'b0;
    #1;
    chk("ena_en", 32'(bus.ctr_en), 32'd0);
    @(posedge clk);
    #1;
    chk("ena_busy", 32'(bus.busy), 32'd0);
    chk("ena_valid", 32'(bus.result_valid), 32'd0);
    chk("ena_keep_result", 32'(bus.result), 32'd10);
    @(negedge clk);
    ena = 1'b1;

    // Asynchronous reset during COUNT
    pins_low();
    arm_pulse();
    start_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_en", 32'(bus.ctr_en), 32'd0);
    chk("arst_load", 32'(bus.ctr_load), 32'd0);
    chk("arst_valid", 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Measurement after reset still works
    measure("post_rst", 15, 1'b1, 8'd15, 1'b0);
    ack_result();

    chk("load_en_exclusive", 32'(both_hi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
